// File: rtl/alu_arbiter_seq.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters,
// with registered ALU operands, a programmable execute window and a valid/ready response.
module alu_arbiter_seq #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    input  logic [1:0]       req_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    output logic             alu_s2,
    input  logic [WIDTH-1:0] alu_f,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic [WIDTH-1:0] last_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t     state, state_n;
    logic [3:0] cnt;
    logic       rr;
    logic       gnt;
    logic       hs;
    logic       capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        req_ready  = '0;
        gnt        = (req_valid == 2'b11) ? rr : req_valid[1];
        hs         = 1'b0;
        capture    = 1'b0;
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                // ready mirrors valid for the granted side, so ready alone marks a handshake
                req_ready[gnt] = req_valid[gnt];
                hs             = req_valid[gnt];
                if (hs) state_n = EXEC;
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rr          <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_s       <= '0;
            alu_s2      <= 1'b0;
            resp_id     <= 1'b0;
            resp_data   <= '0;
            last_result <= '0;
        end else begin
            if (hs) begin
                alu_a           <= req_chain[gnt] ? last_result : (gnt ? req1_a : req0_a);
                alu_b           <= gnt ? req1_b : req0_b;
                {alu_s2, alu_s} <= gnt ? req1_op : req0_op;
                resp_id         <= gnt;
                rr              <= ~gnt;
                cnt             <= CNT_INIT;
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                resp_data   <= alu_f;
                last_result <= alu_f;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Bench for alu_arbiter_seq: transaction-level model checked every cycle, directed
// scenarios with literal expectations, and a randomized phase.
module tb_alu_arbiter_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance, EXEC_CYCLES=1
    logic [1:0] req_valid, req_ready, req_chain;
    logic [7:0] r0a, r1a, r0b, r1b;
    logic [2:0] r0op, r1op;
    logic [7:0] alu_a, alu_b, alu_f, resp_data, last_result;
    logic [1:0] alu_s;
    logic       alu_s2, resp_valid, resp_ready, resp_id, busy;

    // second instance, EXEC_CYCLES=3
    logic [1:0] req_valid_3, req_ready_3, req_chain_3;
    logic [7:0] r0a_3, r1a_3, r0b_3, r1b_3;
    logic [2:0] r0op_3, r1op_3;
    logic [7:0] alu_a_3, alu_b_3, alu_f_3, resp_data_3, last_result_3;
    logic [1:0] alu_s_3;
    logic       alu_s2_3, resp_valid_3, resp_ready_3, resp_id_3, busy_3;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a + 8'd1;
            3'b011:  return a - 8'd1;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign alu_f   = alu_fn(alu_a, alu_b, {alu_s2, alu_s});
    assign alu_f_3 = alu_fn(alu_a_3, alu_b_3, {alu_s2_3, alu_s_3});

    alu_arbiter_seq #(.WIDTH(8), .EXEC_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(r0a), .req1_a(r1a), .req0_b(r0b), .req1_b(r1b),
        .req0_op(r0op), .req1_op(r1op), .req_chain(req_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_s2(alu_s2), .alu_f(alu_f),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .last_result(last_result), .busy(busy)
    );

    alu_arbiter_seq #(.WIDTH(8), .EXEC_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_3), .req_ready(req_ready_3),
        .req0_a(r0a_3), .req1_a(r1a_3), .req0_b(r0b_3), .req1_b(r1b_3),
        .req0_op(r0op_3), .req1_op(r1op_3), .req_chain(req_chain_3),
        .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_s(alu_s_3), .alu_s2(alu_s2_3), .alu_f(alu_f_3),
        .resp_valid(resp_valid_3), .resp_ready(resp_ready_3), .resp_id(resp_id_3),
        .resp_data(resp_data_3), .last_result(last_result_3), .busy(busy_3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // transaction-level model: a request accepted in cycle n owns the ALU for
    // cycles n+1.., its result becomes visible at cycle n+1+EXEC and stays
    // pending until accepted on the response side.
    localparam int EC = 1;
    int         cyc = 0;
    bit         pend;
    int         t_rdy;
    logic       m_rr, m_id;
    logic [7:0] m_a, m_b, m_res, m_data, m_last;
    logic [2:0] m_op;
    logic [1:0] m_acc;

    always @(negedge clk) begin
        logic       g, e_rv;
        logic [1:0] e_rdy;
        m_acc = 2'b00;
        if (!rst_n) begin
            pend = 0; m_rr = 0; m_id = 0; m_a = 0; m_b = 0; m_op = 0;
            m_res = 0; m_data = 0; m_last = 0;
            chk("reset_outs", {req_ready, resp_valid, busy, resp_id, alu_s2, alu_s},
                32'h0);
            chk("reset_data", {alu_a, alu_b, resp_data, last_result}, 32'h0);
        end else begin
            if (pend && cyc >= t_rdy) begin
                m_data = m_res;
                m_last = m_res;
            end
            e_rv  = pend && cyc >= t_rdy;
            g     = (req_valid == 2'b11) ? m_rr : req_valid[1];
            e_rdy = (!pend && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", req_ready, e_rdy);
            chk("resp_valid", resp_valid, e_rv);
            chk("busy", busy, pend);
            chk("alu_inputs", {alu_s2, alu_s, alu_a, alu_b}, {m_op, m_a, m_b});
            chk("resp_id", resp_id, m_id);
            chk("resp_data", resp_data, m_data);
            chk("last_result", last_result, m_last);
            if (e_rv && resp_ready) begin
                pend = 0;
            end else if (e_rdy != 2'b00) begin
                m_acc = e_rdy;
                m_a   = req_chain[g] ? m_last : (g ? r1a : r0a);
                m_b   = g ? r1b : r0b;
                m_op  = g ? r1op : r0op;
                m_res = alu_fn(m_a, m_b, m_op);
                m_id  = g;
                m_rr  = ~g;
                pend  = 1;
                t_rdy = cyc + 1 + EC;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issue one request on the main instance and wait for its response
    task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input bit ch, output int wait_rdy,
                         output int lat, output logic [7:0] a_seen, output logic [7:0] data);
        tick();
        if (id) begin r1a = a; r1b = b; r1op = op; end
        else    begin r0a = a; r0b = b; r0op = op; end
        req_chain[id] = ch;
        req_valid[id] = 1'b1;
        wait_rdy = 0;
        @(negedge clk);
        while (!req_ready[id] && wait_rdy < 20) begin
            @(negedge clk);
            wait_rdy++;
        end
        if (wait_rdy >= 20) chk("do_op_grant_timeout", 0, 1);
        tick();
        req_valid[id] = 1'b0;
        req_chain[id] = 1'b0;
        @(negedge clk);
        a_seen = alu_a;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) chk("do_op_resp_timeout", 0, 1);
        data = resp_data;
    endtask

    initial begin
        int         w, l, ng, r;
        int         gcyc[4];
        logic       gid[4];
        logic [7:0] sa, d, snap_d;
        logic       snap_id;

        req_valid = 0; req_chain = 0; r0a = 0; r1a = 0; r0b = 0; r1b = 0; r0op = 0; r1op = 0;
        resp_ready = 1;
        req_valid_3 = 0; req_chain_3 = 0; r0a_3 = 0; r1a_3 = 0; r0b_3 = 0; r1b_3 = 0;
        r0op_3 = 0; r1op_3 = 0; resp_ready_3 = 1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        // EXEC_CYCLES=3: operands held for three cycles, response on the fourth
        tick();
        r0a_3 = 8'h12; r0b_3 = 8'h34; r0op_3 = 3'b000; req_valid_3 = 2'b01;
        @(negedge clk);
        chk("ec3_ready", req_ready_3, 2'b01);
        tick();
        req_valid_3 = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ec3_alu_hold", {alu_a_3, alu_b_3}, 16'h1234);
            chk("ec3_no_resp", resp_valid_3, 0);
        end
        @(negedge clk);
        chk("ec3_resp_valid", resp_valid_3, 1);
        chk("ec3_resp_data", resp_data_3, 8'h46);

        // single op on requester 0
        do_op(1'b0, 8'h3C, 8'h05, 3'b000, 1'b0, w, l, sa, d);
        chk("single_ready_cycle0", w, 0);
        chk("single_alu_a", sa, 8'h3C);
        chk("single_alu_b", alu_b, 8'h05);
        chk("single_latency", l, 2);
        chk("single_resp_id", resp_id, 0);
        chk("single_resp_data", d, 8'h41);

        // accumulator chain on requester 1
        do_op(1'b1, 8'hF0, 8'h20, 3'b000, 1'b0, w, l, sa, d);
        chk("chain_first", d, 8'h10);
        do_op(1'b1, 8'hAA, 8'h0F, 3'b101, 1'b1, w, l, sa, d);
        chk("chain_alu_a", sa, 8'h10);
        chk("chain_resp_data", d, 8'h1F);
        chk("chain_last_result", last_result, 8'h1F);
        chk("chain_resp_id", resp_id, 1);

        // contention with both requesters held valid
        tick();
        r0a = 8'h01; r0b = 8'h02; r0op = 3'b000; r1a = 8'h10; r1b = 8'h20; r1op = 3'b000;
        req_valid = 2'b11;
        ng = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00 && ng < 4) begin
                gcyc[ng] = k;
                gid[ng]  = req_ready[1];
                ng++;
            end
            if (resp_valid) chk("contend_resp_id", resp_id, (k / 3) % 2);
        end
        chk("contend_grants", ng, 4);
        for (int j = 0; j < 4; j++) begin
            if (j < ng) begin
                chk("contend_order", gid[j], j % 2);
                chk("contend_spacing", gcyc[j], 3 * j);
            end
        end
        tick();
        req_valid = 2'b00;
        repeat (3) tick();

        // backpressure: response held for five cycles, no grant meanwhile
        resp_ready = 0;
        r0a = 8'h07; r0b = 8'h09; r0op = 3'b110;
        req_valid = 2'b01;
        w = 0;
        @(negedge clk);
        while (!req_ready[0] && w < 20) begin @(negedge clk); w++; end
        tick();
        req_valid = 2'b11;
        w = 0;
        @(negedge clk);
        while (!resp_valid && w < 20) begin @(negedge clk); w++; end
        if (w >= 20) chk("bp_resp_timeout", 0, 1);
        snap_d = resp_data; snap_id = resp_id;
        chk("bp_data_value", snap_d, 8'h0E);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            chk("bp_data_stable", {resp_id, resp_data}, {snap_id, snap_d});
            chk("bp_no_grant", req_ready, 2'b00);
            chk("bp_valid_held", resp_valid, 1);
        end
        @(posedge clk);
        #1 resp_ready = 1;
        @(negedge clk);
        chk("bp_no_grant_on_release", req_ready, 2'b00);
        tick();
        @(negedge clk);
        chk("bp_grant_after_idle", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        repeat (4) tick();

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && !m_acc[i]) begin
                    if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(1) == 1);
                    req_chain[i] = ($urandom_range(3) == 0);
                    r = $urandom;
                    if (i == 0) begin r0a = r[7:0]; r0b = r[15:8]; r0op = r[18:16]; end
                    else        begin r1a = r[7:0]; r1b = r[15:8]; r1op = r[18:16]; end
                end
            end
            resp_ready = ($urandom_range(3) != 0);
        end
        tick();
        req_valid = 0; req_chain = 0; resp_ready = 1;
        repeat (6) tick();

        // reset while in EXEC aborts the transaction
        r0a = 8'h55; r0b = 8'h11; r0op = 3'b000;
        req_valid = 2'b01;
        w = 0;
        @(negedge clk);
        while (!req_ready[0] && w < 20) begin @(negedge clk); w++; end
        tick();
        req_valid = 2'b00;
        chk("rst_in_exec", busy, 1);
        rst_n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_resp", resp_valid, 0);
            chk("rst_last_result", last_result, 0);
        end
        @(posedge clk);
        #2 rst_n = 1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_first_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, total=%0d", total);
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter_seq.md
Name: alu_arbiter_seq

Overview:
Shares the team's single combinational 8-bit ALU datapath between two requesters (req0, req1). The ALU is arithmetic when op[2]=0 and logic when op[2]=1, with op[1:0] as the internal select. The block arbitrates round-robin, registers operands and opcode onto the ALU inputs, and holds them for EXEC_CYCLES. It then captures the ALU output and returns it to the granted requester over a valid/ready response channel. An optional chain bit lets a request substitute the last captured result for operand A (accumulator-style sequences).

Parameters:
WIDTH, 8, operand/result width
EXEC_CYCLES, 1, cycles ALU inputs are held stable before capture (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester accept; combinational from state and grant
req0_a, req1_a  in  WIDTH each  operand A
req0_b, req1_b  in  WIDTH each  operand B
req0_op, req1_op  in  3 each  {S2,S[1:0]} ALU opcode
req_chain  in  2  1 = use last_result as operand A for that requester
alu_a, alu_b  out  WIDTH  registered ALU operands
alu_s  out  2  registered internal select
alu_s2  out  1  registered external select
alu_f  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_s/alu_s2
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_id  out  1  requester that owns resp_data
resp_data  out  WIDTH  captured ALU result
last_result  out  WIDTH  most recent captured result
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0) clears all outputs and registers to 0: alu_a, alu_b, alu_s, alu_s2, resp_valid, resp_id, resp_data, last_result, busy. State=IDLE. Round-robin pointer rr=0, meaning requester 0 has priority.
- States: IDLE, EXEC, RESP.
- IDLE, grant rule:
  - Only one valid: grant that requester.
  - Both valid: grant rr.
  - req_ready[g]=1 only for the granted g in IDLE; otherwise 0.
- Handshake (req_valid[g] & req_ready[g]) latches the following, then enters EXEC with the exec counter = EXEC_CYCLES-1:
  - alu_a = req_chain[g] ? last_result : reqg_a
  - alu_b = reqg_b
  - {alu_s2, alu_s} = reqg_op
  - resp_id = g
  - rr = ~g
- EXEC: alu_* held constant. Counter decrements each cycle. When the counter is 0, capture alu_f into resp_data and last_result, then go to RESP.
- RESP: resp_valid=1. resp_data and resp_id are stable until resp_ready. On resp_valid & resp_ready go to IDLE, resp_valid=0 next cycle.
- No new grant is made in the cycle leaving RESP; IDLE must be visited for at least 1 cycle.
- Latency with EXEC_CYCLES=1: handshake at edge t, resp_valid high from t+2. Minimum issue interval is 3 cycles when resp_ready is held high.
- Requesters must hold inputs while req_valid=1 and req_ready=0. A request deasserted before grant is dropped silently.
- Chain with no prior result uses last_result=0.
- Widths: no carry/flag output; the result is exactly WIDTH bits as supplied by alu_f.
- Reset mid-operation aborts the transaction: no response, state=IDLE, rr=0, last_result=0.

Test Plan:
All scenarios use a bench ALU model: op 000 → A+B mod 256, 100 → A&B, 101 → A|B.
- Reset while in EXEC → resp_valid stays 0. All outputs read 0 next cycle. First request after reset with both req_valid=1 is granted to requester 0.
- Single op: req0 a=8'h3C, b=8'h05, op=000 → req_ready[0] in cycle 0. alu_a=3C, alu_b=05 in cycle 1. Cycle 2: resp_valid=1, resp_id=0, resp_data=8'h41.
- Contention: req_valid=2'b11 held, resp_ready=1 → grants alternate 0,1,0,1. Each grant is 3 cycles apart; resp_id matches the sequence.
- Backpressure: resp_ready=0 for 5 cycles in RESP → resp_data/resp_id are stable, req_ready=2'b00, and no new grant until 1 cycle after resp_ready=1.
- Chain: req1 a=8'hF0, b=8'h20, op=000 → 8'h10. Then req1 chain=1, b=8'h0F, op=101 → alu_a=8'h10, resp_data=8'h1F, last_result=8'h1F.
- EXEC_CYCLES=3: handshake at t → alu_* stable for cycles t+1..t+3, resp_valid rises at t+4.
